instr_decoder: RTL and testbench
================================

INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have parameter BUFF_TABLE_DEPTH, default 10, number of buffer-table entries.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width: opcode[31:27], op_spec[26:21], loop_id[20:16], imm[15:0].
REQ-003 SHALL have port CLK  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port instr_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port instr_data  input  INSTR_W  instruction word.
REQ-007 SHALL have port instr_ready  output  1  decoder can accept an instruction.
REQ-008 SHALL have port buf_wr_en  output  1  one-cycle buffer-table write strobe.
REQ-009 SHALL have port buf_wr_idx  output  4  buffer-table entry index.
REQ-010 SHALL have port buf_wr_data  output  24  {opcode[4:0], mem_width[2:0], num_words[15:0]}.
REQ-011 SHALL have port buf_count  output  4  valid buffer-table entries.
REQ-012 SHALL have port loop_wr_en  output  1  loop-config strobe; loop_id_o output 5, loop_iter output 16 accompany it.
REQ-013 SHALL have port gen_addr_valid  output  1  gen-addr strobe; ga_loop_id output 5, ga_stride output 16, ga_buf output 3 (one-hot IBUF=001, WBUF=010, OBUF=100) accompany it.
REQ-014 SHALL have port compute_start  output  1  one-cycle pulse to array.
REQ-015 SHALL have port compute_done  input  1  array finished.
REQ-016 SHALL have port blk_done  output  1  one-cycle end-of-block pulse.
REQ-017 SHALL have port illegal_op  output  1  sticky error flag.

Function
REQ-018 Opcode encoding SHALL be SETUP=0, LD_MEM=1, ST_MEM=2, RD_BUF=3, WR_BUF=4, GEN_ADDR=5, COMPUTE=6, LOOP=7, BLK_END=8; 9-31 illegal.
REQ-019 Transfer SHALL occur only on a CLK edge with instr_valid && instr_ready; all strobes/data outputs registered, asserted exactly the cycle after transfer, for one cycle.
REQ-020 FSM states SHALL be IDLE, RUN, COMPUTE, END; instr_ready=1 in IDLE and RUN only.
REQ-021 IDLE: SETUP -> RUN, buf_count:=0; any other opcode dropped, illegal_op:=1, stay IDLE.
REQ-022 RUN, LD_MEM/ST_MEM/RD_BUF/WR_BUF: if buf_count<BUFF_TABLE_DEPTH, buf_wr_en=1, buf_wr_idx=buf_count, mem_width=op_spec[2:0], num_words=imm, buf_count+=1 in same cycle as strobe.
REQ-023 RUN, table-op with buf_count==BUFF_TABLE_DEPTH: no write, buf_count holds (no wrap), illegal_op:=1.
REQ-024 RUN, LOOP: loop_wr_en=1, loop_id_o=loop_id, loop_iter=imm.
REQ-025 RUN, GEN_ADDR: op_spec[2:0] one-hot -> gen_addr_valid=1, ga_buf=op_spec[2:0], ga_loop_id=loop_id, ga_stride=imm; otherwise no strobe, illegal_op:=1.
REQ-026 RUN, COMPUTE -> COMPUTE state; compute_start=1 first cycle in COMPUTE only.
REQ-027 COMPUTE: compute_done sampled from cycle after compute_start; compute_done coincident with compute_start or outside COMPUTE ignored; on done -> RUN.
REQ-028 RUN, SETUP: restart, buf_count:=0, stay RUN.
REQ-029 RUN, BLK_END -> END; END lasts one cycle with blk_done=1, buf_count:=0, -> IDLE.
REQ-030 RUN, illegal opcode: dropped, illegal_op:=1, state unchanged.
REQ-031 illegal_op SHALL stay 1 until RST.

Reset
REQ-032 RST high SHALL immediately force IDLE, buf_count=0, illegal_op=0, all strobes 0, data outputs 0, instr_ready=1 after RST deasserts.
REQ-033 RST mid-COMPUTE or mid-strobe SHALL abort without further pulses; pending compute_done ignored.

Verification
REQ-034 SETUP, LD_MEM(op_spec=3, imm=64), RD_BUF(imm=8) -> buf_wr_en idx 0 data {1,3,64}, then idx 1 {3,0,8}; buf_count=2.
REQ-035 SETUP + 11 LD_MEM -> 10 writes idx 0-9, 11th dropped, buf_count=10, illegal_op=1.
REQ-036 GEN_ADDR op_spec=2, loop_id=4, imm=16 -> ga_buf=010, ga_loop_id=4, ga_stride=16; op_spec=3 -> no strobe, illegal_op=1.
REQ-037 COMPUTE with compute_done high for 5 cycles from start -> compute_start one cycle, instr_ready=0 until done accepted, done in start cycle ignored.
REQ-038 BLK_END after 3 entries -> blk_done one cycle, buf_count=0, IDLE; next LOOP in IDLE -> illegal_op=1.
REQ-039 RST asserted during COMPUTE -> IDLE, outputs zero, no compute_start/blk_done afterwards.

Source files
------------

// File: rtl/instr_decoder.sv
// ----------------------------------------------------------------------------
// instr_decoder
//
// Purpose:
//   Accepts instruction words over a valid/ready handshake and turns them
//   into registered, one-cycle configuration strobes:
//     * buffer-table writes (LD_MEM / ST_MEM / RD_BUF / WR_BUF)
//     * loop configuration (LOOP)
//     * address-generator configuration (GEN_ADDR)
//     * compute kick-off and completion handshake with the array (COMPUTE)
//     * end-of-block pulse (BLK_END)
//   Anything malformed or out of sequence is dropped and latches the sticky
//   illegal_op flag until reset.
//
// Instruction layout (bits 31:0 of instr_data):
//   opcode[31:27]  op_spec[26:21]  loop_id[20:16]  imm[15:0]
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   instr_valid/_data   upstream instruction, instr_ready back-pressure
//   buf_wr_en/_idx/_data buffer-table write strobe, index, {opcode,width,words}
//   buf_count           number of valid buffer-table entries
//   loop_wr_en, loop_id_o, loop_iter               loop-config strobe + data
//   gen_addr_valid, ga_loop_id, ga_stride, ga_buf  gen-addr strobe + data
//   compute_start/compute_done                     array handshake
//   blk_done            end-of-block pulse
//   illegal_op          sticky error flag
//
// BUFF_TABLE_DEPTH must fit the 4-bit index/count outputs (1..15).
// ----------------------------------------------------------------------------
module instr_decoder #(
   parameter int BUFF_TABLE_DEPTH = 10,
   parameter int INSTR_W          = 32
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr_data,
   output logic               instr_ready,
   output logic               buf_wr_en,
   output logic [3:0]         buf_wr_idx,
   output logic [23:0]        buf_wr_data,
   output logic [3:0]         buf_count,
   output logic               loop_wr_en,
   output logic [4:0]         loop_id_o,
   output logic [15:0]        loop_iter,
   output logic               gen_addr_valid,
   output logic [4:0]         ga_loop_id,
   output logic [15:0]        ga_stride,
   output logic [2:0]         ga_buf,
   output logic               compute_start,
   input  logic               compute_done,
   output logic               blk_done,
   output logic               illegal_op
);

   localparam logic [4:0] OP_SETUP    = 5'd0;
   localparam logic [4:0] OP_LD_MEM   = 5'd1;
   localparam logic [4:0] OP_ST_MEM   = 5'd2;
   localparam logic [4:0] OP_RD_BUF   = 5'd3;
   localparam logic [4:0] OP_WR_BUF   = 5'd4;
   localparam logic [4:0] OP_GEN_ADDR = 5'd5;
   localparam logic [4:0] OP_COMPUTE  = 5'd6;
   localparam logic [4:0] OP_LOOP     = 5'd7;
   localparam logic [4:0] OP_BLK_END  = 5'd8;

   localparam logic [3:0] DEPTH = 4'(BUFF_TABLE_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_END     = 2'd3
   } state_t;

   // instruction fields
   logic [4:0]  opcode;
   logic [5:0]  op_spec;
   logic [4:0]  loop_id;
   logic [15:0] imm;
   logic        fire;

   assign opcode  = instr_data[31:27];
   assign op_spec = instr_data[26:21];
   assign loop_id = instr_data[20:16];
   assign imm     = instr_data[15:0];

   // only op_spec[2:0] carries meaning for any opcode
   logic unused_spec_bits;
   assign unused_spec_bits = &{1'b0, op_spec[5:3]};

   state_t      state_reg, state_next;
   logic [3:0]  count_reg, count_next;
   logic        illegal_reg, illegal_next;
   logic        buf_wr_en_reg, buf_wr_en_next;
   logic [3:0]  buf_wr_idx_reg, buf_wr_idx_next;
   logic [23:0] buf_wr_data_reg, buf_wr_data_next;
   logic        loop_wr_en_reg, loop_wr_en_next;
   logic [4:0]  loop_id_reg, loop_id_next;
   logic [15:0] loop_iter_reg, loop_iter_next;
   logic        ga_valid_reg, ga_valid_next;
   logic [4:0]  ga_loop_id_reg, ga_loop_id_next;
   logic [15:0] ga_stride_reg, ga_stride_next;
   logic [2:0]  ga_buf_reg, ga_buf_next;
   logic        compute_start_reg, compute_start_next;
   logic        blk_done_reg, blk_done_next;

   assign instr_ready = (state_reg == ST_IDLE) || (state_reg == ST_RUN);
   assign fire        = instr_valid && instr_ready;

   // next-state / next-output logic
   always_comb begin
      state_next         = state_reg;
      count_next         = count_reg;
      illegal_next       = illegal_reg;
      buf_wr_en_next     = 1'b0;
      buf_wr_idx_next    = buf_wr_idx_reg;
      buf_wr_data_next   = buf_wr_data_reg;
      loop_wr_en_next    = 1'b0;
      loop_id_next       = loop_id_reg;
      loop_iter_next     = loop_iter_reg;
      ga_valid_next      = 1'b0;
      ga_loop_id_next    = ga_loop_id_reg;
      ga_stride_next     = ga_stride_reg;
      ga_buf_next        = ga_buf_reg;
      compute_start_next = 1'b0;
      blk_done_next      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (fire) begin
               if (opcode == OP_SETUP) begin
                  state_next = ST_RUN;
                  count_next = 4'd0;
               end else begin
                  illegal_next = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (fire) begin
               case (opcode)
                  OP_SETUP: count_next = 4'd0;

                  OP_LD_MEM, OP_ST_MEM, OP_RD_BUF, OP_WR_BUF: begin
                     // a full table saturates: no write, no wrap
                     if (count_reg < DEPTH) begin
                        buf_wr_en_next   = 1'b1;
                        buf_wr_idx_next  = count_reg;
                        buf_wr_data_next = {opcode, op_spec[2:0], imm};
                        count_next       = count_reg + 4'd1;
                     end else begin
                        illegal_next = 1'b1;
                     end
                  end

                  OP_LOOP: begin
                     loop_wr_en_next = 1'b1;
                     loop_id_next    = loop_id;
                     loop_iter_next  = imm;
                  end

                  OP_GEN_ADDR: begin
                     // target buffer select must be exactly one-hot
                     case (op_spec[2:0])
                        3'b001, 3'b010, 3'b100: begin
                           ga_valid_next   = 1'b1;
                           ga_buf_next     = op_spec[2:0];
                           ga_loop_id_next = loop_id;
                           ga_stride_next  = imm;
                        end
                        default: illegal_next = 1'b1;
                     endcase
                  end

                  OP_COMPUTE: begin
                     state_next         = ST_COMPUTE;
                     compute_start_next = 1'b1;
                  end

                  OP_BLK_END: begin
                     state_next    = ST_END;
                     blk_done_next = 1'b1;
                     count_next    = 4'd0;
                  end

                  default: illegal_next = 1'b1;
               endcase
            end
         end

         ST_COMPUTE: begin
            // compute_start_reg is high only in the first COMPUTE cycle; a
            // done seen alongside the start pulse belongs to an older job
            if (compute_done && !compute_start_reg) begin
               state_next = ST_RUN;
            end
         end

         ST_END: state_next = ST_IDLE;

         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg         <= ST_IDLE;
         count_reg         <= 4'd0;
         illegal_reg       <= 1'b0;
         buf_wr_en_reg     <= 1'b0;
         buf_wr_idx_reg    <= 4'd0;
         buf_wr_data_reg   <= 24'd0;
         loop_wr_en_reg    <= 1'b0;
         loop_id_reg       <= 5'd0;
         loop_iter_reg     <= 16'd0;
         ga_valid_reg      <= 1'b0;
         ga_loop_id_reg    <= 5'd0;
         ga_stride_reg     <= 16'd0;
         ga_buf_reg        <= 3'd0;
         compute_start_reg <= 1'b0;
         blk_done_reg      <= 1'b0;
      end else begin
         state_reg         <= state_next;
         count_reg         <= count_next;
         illegal_reg       <= illegal_next;
         buf_wr_en_reg     <= buf_wr_en_next;
         buf_wr_idx_reg    <= buf_wr_idx_next;
         buf_wr_data_reg   <= buf_wr_data_next;
         loop_wr_en_reg    <= loop_wr_en_next;
         loop_id_reg       <= loop_id_next;
         loop_iter_reg     <= loop_iter_next;
         ga_valid_reg      <= ga_valid_next;
         ga_loop_id_reg    <= ga_loop_id_next;
         ga_stride_reg     <= ga_stride_next;
         ga_buf_reg        <= ga_buf_next;
         compute_start_reg <= compute_start_next;
         blk_done_reg      <= blk_done_next;
      end
   end

   assign buf_count      = count_reg;
   assign illegal_op     = illegal_reg;
   assign buf_wr_en      = buf_wr_en_reg;
   assign buf_wr_idx     = buf_wr_idx_reg;
   assign buf_wr_data    = buf_wr_data_reg;
   assign loop_wr_en     = loop_wr_en_reg;
   assign loop_id_o      = loop_id_reg;
   assign loop_iter      = loop_iter_reg;
   assign gen_addr_valid = ga_valid_reg;
   assign ga_loop_id     = ga_loop_id_reg;
   assign ga_stride      = ga_stride_reg;
   assign ga_buf         = ga_buf_reg;
   assign compute_start  = compute_start_reg;
   assign blk_done       = blk_done_reg;

endmodule

// File: tb/tb_instr_decoder.sv
// ----------------------------------------------------------------------------
// tb_instr_decoder
//
// Self-checking bench for instr_decoder: directed scenarios for the block's
// corner cases followed by randomized instruction streams. Expected values
// come from a transaction-level model of the decoder (mode, table fill level,
// error flag) that predicts the effect of each accepted instruction.
// ----------------------------------------------------------------------------
module tb_instr_decoder;

   localparam int DEPTH  = 10;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_COMP = 2;
   localparam int M_END  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr_data = 32'd0;
   logic        compute_done = 1'b0;
   logic        instr_ready;
   logic        buf_wr_en;
   logic [3:0]  buf_wr_idx;
   logic [23:0] buf_wr_data;
   logic [3:0]  buf_count;
   logic        loop_wr_en;
   logic [4:0]  loop_id_o;
   logic [15:0] loop_iter;
   logic        gen_addr_valid;
   logic [4:0]  ga_loop_id;
   logic [15:0] ga_stride;
   logic [2:0]  ga_buf;
   logic        compute_start;
   logic        blk_done;
   logic        illegal_op;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_mode    = M_IDLE;
   int m_count   = 0;
   bit m_illegal = 1'b0;

   instr_decoder dut (
      .CLK           (clk),
      .RST           (rst),
      .instr_valid   (instr_valid),
      .instr_data    (instr_data),
      .instr_ready   (instr_ready),
      .buf_wr_en     (buf_wr_en),
      .buf_wr_idx    (buf_wr_idx),
      .buf_wr_data   (buf_wr_data),
      .buf_count     (buf_count),
      .loop_wr_en    (loop_wr_en),
      .loop_id_o     (loop_id_o),
      .loop_iter     (loop_iter),
      .gen_addr_valid(gen_addr_valid),
      .ga_loop_id    (ga_loop_id),
      .ga_stride     (ga_stride),
      .ga_buf        (ga_buf),
      .compute_start (compute_start),
      .compute_done  (compute_done),
      .blk_done      (blk_done),
      .illegal_op    (illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_count"}, 32'(buf_count), 32'(m_count));
      check_eq({tag, "_illegal"}, 32'(illegal_op), 32'(m_illegal));
      check_eq({tag, "_ready"}, 32'(instr_ready), 32'((m_mode == M_IDLE) || (m_mode == M_RUN)));
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_strobes"}, 32'({buf_wr_en, loop_wr_en, gen_addr_valid, compute_start, blk_done}), 32'd0);
   endtask

   task automatic model_reset();
      m_mode    = M_IDLE;
      m_count   = 0;
      m_illegal = 1'b0;
   endtask

   // asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_quiet("rst");
      check_eq("rst_data", 32'({buf_wr_idx, buf_wr_data, loop_id_o, loop_iter}), 32'd0);
      check_eq("rst_ga", 32'({ga_loop_id, ga_stride, ga_buf}), 32'd0);
      check_state("rst");
      @(negedge clk);
      rst = 1'b0;
      $display("reset applied");
   endtask

   // wait out a COMPUTE job; pattern 1 holds done high from the start cycle
   task automatic run_compute(input int pattern);
      bit done_prev;
      bit first = 1'b1;
      compute_done = (pattern == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 30; i++) begin
         done_prev = compute_done;
         @(posedge clk);
         #1;
         check_eq("cstart_once", 32'(compute_start), 32'd0);
         if (!first && done_prev) begin
            m_mode = M_RUN;
            check_eq("compute_exit_ready", 32'(instr_ready), 32'd1);
            break;
         end
         check_eq("compute_busy_ready", 32'(instr_ready), 32'd0);
         first = 1'b0;
         if (pattern == 1 || i >= 8) compute_done = 1'b1;
         else compute_done = ($urandom_range(0, 2) == 0);
      end
      if (m_mode != M_RUN) begin
         check_eq("compute_timeout", 32'(instr_ready), 32'd1);
         m_mode = M_RUN;
      end
      compute_done = 1'b0;
      $display("compute finished");
   endtask

   // one instruction transfer, predicted by the model and checked the cycle after
   task automatic send(input logic [4:0] op, input logic [5:0] spec, input logic [4:0] lid,
                       input logic [15:0] imm, input bit hold_compute);
      bit          e_wr = 0, e_loop = 0, e_ga = 0, e_start = 0, e_blk = 0;
      logic [3:0]  e_idx = 4'd0;
      logic [23:0] e_data = 24'd0;
      @(negedge clk);
      instr_data   = {op, spec, lid, imm};
      instr_valid  = 1'b1;
      compute_done = 1'($urandom_range(0, 1));  // not in COMPUTE: must be ignored
      check_eq("ready_pre", 32'(instr_ready), 32'd1);

      if (m_mode == M_IDLE) begin
         if (op == 5'd0) begin
            m_mode  = M_RUN;
            m_count = 0;
         end else begin
            m_illegal = 1'b1;
         end
      end else begin
         if (op == 5'd0) begin
            m_count = 0;
         end else if (op >= 5'd1 && op <= 5'd4) begin
            if (m_count < DEPTH) begin
               e_wr   = 1;
               e_idx  = 4'(m_count);
               e_data = {op, spec[2:0], imm};
               m_count++;
            end else begin
               m_illegal = 1'b1;
            end
         end else if (op == 5'd7) begin
            e_loop = 1;
         end else if (op == 5'd5) begin
            if (spec[2:0] inside {3'd1, 3'd2, 3'd4}) e_ga = 1;
            else m_illegal = 1'b1;
         end else if (op == 5'd6) begin
            e_start = 1;
            m_mode  = M_COMP;
         end else if (op == 5'd8) begin
            e_blk   = 1;
            m_count = 0;
            m_mode  = M_END;
         end else begin
            m_illegal = 1'b1;
         end
      end

      @(posedge clk);
      #1;
      instr_valid  = 1'b0;
      compute_done = 1'b0;
      $display("instr op=%0d spec=%0d lid=%0d imm=%0d -> wr=%0b loop=%0b ga=%0b start=%0b blk=%0b cnt=%0d ill=%0b",
               op, spec, lid, imm, buf_wr_en, loop_wr_en, gen_addr_valid, compute_start, blk_done,
               buf_count, illegal_op);
      check_eq("buf_wr_en", 32'(buf_wr_en), 32'(e_wr));
      check_eq("loop_wr_en", 32'(loop_wr_en), 32'(e_loop));
      check_eq("gen_addr_valid", 32'(gen_addr_valid), 32'(e_ga));
      check_eq("compute_start", 32'(compute_start), 32'(e_start));
      check_eq("blk_done", 32'(blk_done), 32'(e_blk));
      if (e_wr) begin
         check_eq("buf_wr_idx", 32'(buf_wr_idx), 32'(e_idx));
         check_eq("buf_wr_data", 32'(buf_wr_data), 32'(e_data));
      end
      if (e_loop) begin
         check_eq("loop_id_o", 32'(loop_id_o), 32'(lid));
         check_eq("loop_iter", 32'(loop_iter), 32'(imm));
      end
      if (e_ga) begin
         check_eq("ga_buf", 32'(ga_buf), 32'(spec[2:0]));
         check_eq("ga_loop_id", 32'(ga_loop_id), 32'(lid));
         check_eq("ga_stride", 32'(ga_stride), 32'(imm));
      end
      check_state("post");

      if (m_mode == M_COMP) begin
         if (!hold_compute) run_compute(0);
      end else begin
         @(posedge clk);
         #1;
         if (m_mode == M_END) m_mode = M_IDLE;
         check_quiet("after");
         check_state("after");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] op;

      // reset state
      #1;
      check_quiet("init");
      check_state("init");
      do_reset();

      // two table writes
      send(5'd0, 6'd0, 5'd0, 16'd0, 0);
      send(5'd1, 6'd3, 5'd0, 16'd64, 0);
      send(5'd3, 6'd0, 5'd0, 16'd8, 0);
      check_eq("two_entries", 32'(buf_count), 32'd2);
      check_eq("no_error_yet", 32'(illegal_op), 32'd0);

      // gen-addr, loop, compute with done held from the start cycle, block end
      send(5'd5, 6'd2, 5'd4, 16'd16, 0);
      send(5'd7, 6'd0, 5'd7, 16'd100, 0);
      send(5'd6, 6'd0, 5'd0, 16'd0, 1);
      run_compute(1);
      send(5'd4, 6'd5, 5'd0, 16'd300, 0);
      check_eq("three_entries", 32'(buf_count), 32'd3);
      send(5'd8, 6'd0, 5'd0, 16'd0, 0);
      check_eq("blk_cleared", 32'(buf_count), 32'd0);
      send(5'd7, 6'd0, 5'd1, 16'd9, 0);
      check_eq("loop_in_idle_err", 32'(illegal_op), 32'd1);

      // malformed gen-addr select
      do_reset();
      send(5'd0, 6'd0, 5'd0, 16'd0, 0);
      send(5'd5, 6'd3, 5'd4, 16'd16, 0);
      check_eq("ga_bad_err", 32'(illegal_op), 32'd1);

      // table overflow
      do_reset();
      send(5'd0, 6'd0, 5'd0, 16'd0, 0);
      for (int i = 0; i < 11; i++) send(5'd1, 6'(i), 5'd0, 16'(i * 4), 0);
      check_eq("table_full", 32'(buf_count), 32'd10);
      check_eq("overflow_err", 32'(illegal_op), 32'd1);

      // reset while computing
      do_reset();
      send(5'd0, 6'd0, 5'd0, 16'd0, 0);
      send(5'd6, 6'd0, 5'd0, 16'd0, 1);
      compute_done = 1'b0;
      @(posedge clk);
      #1;
      check_eq("comp_busy", 32'(instr_ready), 32'd0);
      compute_done = 1'b1;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_quiet("abort");
      check_state("abort");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check_quiet("abort_after");
         check_state("abort_after");
      end
      compute_done = 1'b0;
      $display("reset during compute done");

      // randomized streams
      for (int i = 0; i < 300; i++) begin
         if (i % 60 == 0) do_reset();
         if (m_mode == M_IDLE && $urandom_range(0, 9) < 7) op = 5'd0;
         else if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(9, 31));
         else op = 5'($urandom_range(0, 8));
         send(op, 6'($urandom), 5'($urandom), 16'($urandom), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
